// File: rtl/poly_loader_driver_pkg.sv
// Shared poly package: driver and evaluator state encodings, operand-index
// constants, the captured operand set and the operand-select helper.
package poly_loader_driver_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ST_W   = 3;

  // Loader/driver FSM encodings
  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP    = 3'd1;
  localparam logic [ST_W-1:0] ST_PRESS    = 3'd2;
  localparam logic [ST_W-1:0] ST_RELEASE  = 3'd3;
  localparam logic [ST_W-1:0] ST_WAIT_RES = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd5;

  // Downstream evaluator FSM encodings
  localparam logic [ST_W-1:0] EV_ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] EV_ST_LOAD   = 3'd1;
  localparam logic [ST_W-1:0] EV_ST_EVAL   = 3'd2;
  localparam logic [ST_W-1:0] EV_ST_RESULT = 3'd3;

  // Operand index: order in which operands are presented to the evaluator
  localparam logic [IDX_W-1:0] IDX_A = 2'd0;
  localparam logic [IDX_W-1:0] IDX_B = 2'd1;
  localparam logic [IDX_W-1:0] IDX_C = 2'd2;
  localparam logic [IDX_W-1:0] IDX_X = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] x;
  } poly_ops_t;

  // Select the operand driven on the bus for a given index
  function automatic logic [DATA_W-1:0] op_sel(input poly_ops_t ops,
                                                input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] sel;
    case (idx)
      IDX_A:   sel = ops.a;
      IDX_B:   sel = ops.b;
      IDX_C:   sel = ops.c;
      default: sel = ops.x;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/poly_loader_driver.sv
// Polynomial operand loader: presents a, b, c, x to the evaluator with a
// setup / press / release strobe per operand, waits for the evaluator and
// captures its result.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   start                request one transaction (sampled in IDLE only)
//   op_a..op_x           operands, captured on accepted start
//   result_in            evaluator result register
//   go, data_out         load strobe and operand bus to the evaluator
//   busy, done, result   status and captured result
module poly_loader_driver
  import poly_loader_driver_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned RESULT_WAIT  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] op_c,
  input  logic [DATA_W-1:0] op_x,
  input  logic [DATA_W-1:0] result_in,
  output logic              go,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  logic [ST_W-1:0]   state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  poly_ops_t         ops_q,      ops_d;
  logic [DATA_W-1:0] result_q,   result_d;
  logic              go_q,       go_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ops_d    = ops_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ops_d   = '{a: op_a, b: op_b, c: op_c, x: op_x};
          idx_d   = IDX_A;
          cnt_d   = CNT_W'(GAP_CYCLES);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = CNT_W'(PULSE_CYCLES);
          state_d = ST_PRESS;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_PRESS: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RELEASE: begin
        if (idx_q == IDX_X) begin
          cnt_d   = CNT_W'(RESULT_WAIT);
          state_d = ST_WAIT_RES;
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = CNT_W'(GAP_CYCLES);
          state_d = ST_SETUP;
        end
      end
      ST_WAIT_RES: begin
        if (cnt_q <= 8'd1) begin
          cnt_d    = '0;
          result_d = result_in;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        idx_d   = IDX_A;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the state register
    go_d       = (state_d == ST_PRESS);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    data_out_d = '0;
    if ((state_d == ST_SETUP) || (state_d == ST_PRESS) || (state_d == ST_RELEASE)) begin
      data_out_d = op_sel(ops_d, idx_d);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      ops_q      <= '0;
      result_q   <= '0;
      go_q       <= 1'b0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ops_q      <= ops_d;
      result_q   <= result_d;
      go_q       <= go_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign go       = go_q;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_poly_loader_driver.sv
// Directed bench for poly_loader_driver: default-parameter instance wired to a
// behavioural evaluator, plus a PULSE=1/GAP=3/WAIT=5 instance.
module tb_poly_loader_driver;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start0, start1;
  logic [7:0] op_a, op_b, op_c, op_x;
  logic [7:0] res_in0, res_in1;

  logic       go0, busy0, done0;
  logic [7:0] data0, result0;
  logic       go1, busy1, done1;
  logic [7:0] data1, result1;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  poly_loader_driver u_dut0 (
    .clk(clk), .resetn(resetn), .start(start0),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_x(op_x),
    .result_in(res_in0),
    .go(go0), .data_out(data0), .busy(busy0), .done(done0), .result(result0)
  );

  poly_loader_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(3), .RESULT_WAIT(5)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_x(op_x),
    .result_in(res_in1),
    .go(go1), .data_out(data1), .busy(busy1), .done(done1), .result(result1)
  );

  // Behavioural evaluator: latches the bus on each go rise, result = a*x^2 + b*x + c
  logic       ev_prev;
  logic [1:0] ev_idx;
  logic [7:0] ev_a, ev_b, ev_c;
  always @(posedge clk) begin
    if (!resetn) begin
      ev_prev <= 1'b0;
      ev_idx  <= 2'd0;
      ev_a    <= 8'd0;
      ev_b    <= 8'd0;
      ev_c    <= 8'd0;
      res_in0 <= 8'd0;
    end else begin
      ev_prev <= go0;
      if (go0 && !ev_prev) begin
        case (ev_idx)
          2'd0: ev_a <= data0;
          2'd1: ev_b <= data0;
          2'd2: ev_c <= data0;
          default: res_in0 <= 8'(int'(ev_a) * int'(data0) * int'(data0)
                                 + int'(ev_b) * int'(data0) + int'(ev_c));
        endcase
        ev_idx <= ev_idx + 2'd1;
      end
    end
  end

  // Expected outputs in cycle k after the start edge (cycle 0 = start edge)
  function automatic void exp_at(input int k, input int pulse, input int gap,
                                 input int wt, input logic [31:0] ops,
                                 output logic eg, output logic [7:0] ed,
                                 output logic eb, output logic edn);
    int p;
    int tdone;
    int op;
    int j;
    p     = gap + pulse + 1;
    tdone = 4 * p + wt + 1;
    eg = 1'b0; ed = 8'd0; eb = 1'b0; edn = 1'b0;
    if (k >= 1 && k <= 4 * p) begin
      op = (k - 1) / p;
      j  = (k - 1) % p;
      eb = 1'b1;
      eg = (j >= gap) && (j < gap + pulse);
      ed = 8'(ops >> (8 * (3 - op)));
    end else if (k > 4 * p && k < tdone) begin
      eb = 1'b1;
    end else if (k == tdone) begin
      eb  = 1'b1;
      edn = 1'b1;
    end
  endfunction

  // Pulse start for one edge; returns at the negedge of cycle 1
  task automatic launch(input int sel);
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start0 = 1'b0; start1 = 1'b0;
    op_a = 8'd0; op_b = 8'd0; op_c = 8'd0; op_x = 8'd0; res_in1 = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if ({go0, data0, busy0, done0, result0} !== 19'd0) begin
      err_cnt++;
      $display("FAIL reset_dut0 go/data/busy/done/result got %b/%0d/%b/%b/%0d want all 0",
               go0, data0, busy0, done0, result0);
    end
    vec_cnt++;
    if ({go1, data1, busy1, done1, result1} !== 19'd0) begin
      err_cnt++;
      $display("FAIL reset_dut1 go/data/busy/done/result got %b/%0d/%b/%b/%0d want all 0",
               go1, data1, busy1, done1, result1);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({go0, busy0, done0} !== 3'b000) begin
      err_cnt++;
      $display("FAIL idle_no_start go/busy/done got %b/%b/%b want 0/0/0", go0, busy0, done0);
    end
  endtask

  task automatic test_basic();
    logic eg, eb, edn;
    logic [7:0] ed;
    logic prev;
    int rises, first_rise, done_cyc;
    op_a = 8'd1; op_b = 8'd2; op_c = 8'd3; op_x = 8'd4;
    launch(0);
    prev = 1'b0; rises = 0; first_rise = -1; done_cyc = -1;
    for (int k = 1; k <= 26; k++) begin
      exp_at(k, 2, 1, 6, 32'h01020304, eg, ed, eb, edn);
      vec_cnt++;
      if ({go0, data0, busy0, done0} !== {eg, ed, eb, edn}) begin
        err_cnt++;
        $display("FAIL basic cyc%0d go/data/busy/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 k, go0, data0, busy0, done0, eg, ed, eb, edn);
      end
      if (go0 === 1'b1 && prev !== 1'b1) begin
        rises++;
        if (first_rise < 0) first_rise = k;
      end
      prev = go0;
      if (done0 === 1'b1) done_cyc = k;
      @(negedge clk);
    end
    vec_cnt++;
    if (first_rise != 2) begin
      err_cnt++;
      $display("FAIL basic_first_go got cycle %0d want 2", first_rise);
    end
    vec_cnt++;
    if (rises != 4) begin
      err_cnt++;
      $display("FAIL basic_go_count got %0d want 4", rises);
    end
    vec_cnt++;
    if (done_cyc != 23) begin
      err_cnt++;
      $display("FAIL basic_done_cycle got %0d want 23", done_cyc);
    end
    vec_cnt++;
    if (result0 !== 8'd27) begin
      err_cnt++;
      $display("FAIL basic_result got %0d want 27", result0);
    end
  endtask

  task automatic test_eval();
    int done_cnt, done_cyc;
    op_a = 8'd5; op_b = 8'd0; op_c = 8'd0; op_x = 8'd0;
    launch(0);
    done_cnt = 0; done_cyc = -1;
    for (int k = 1; k <= 26; k++) begin
      if (done0 === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (done_cnt != 1 || done_cyc != 23) begin
      err_cnt++;
      $display("FAIL eval_done got %0d pulses last at %0d want 1 at 23", done_cnt, done_cyc);
    end
    vec_cnt++;
    if (result0 !== 8'd0) begin
      err_cnt++;
      $display("FAIL eval_result got %0d want 0", result0);
    end
  endtask

  task automatic test_back_to_back();
    logic eg, eb, edn;
    logic [7:0] ed;
    logic prev;
    int rises, dones, k;
    bit seen;
    op_a = 8'd1; op_b = 8'd2; op_c = 8'd3; op_x = 8'd4;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    prev = 1'b0; rises = 0; dones = 0;
    for (k = 1; k <= 23; k++) begin
      exp_at(k, 2, 1, 6, 32'h01020304, eg, ed, eb, edn);
      vec_cnt++;
      if ({go0, data0, busy0, done0} !== {eg, ed, eb, edn}) begin
        err_cnt++;
        $display("FAIL b2b cyc%0d go/data/busy/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 k, go0, data0, busy0, done0, eg, ed, eb, edn);
      end
      if (go0 === 1'b1 && prev !== 1'b1) rises++;
      prev = go0;
      if (done0 === 1'b1) dones++;
      @(negedge clk);
    end
    vec_cnt++;
    if (rises != 4 || dones != 1) begin
      err_cnt++;
      $display("FAIL b2b_first_txn got %0d go pulses %0d done want 4 and 1", rises, dones);
    end
    vec_cnt++;
    if (busy0 !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_idle_gap cyc24 busy got %b want 0", busy0);
    end
    @(negedge clk);
    vec_cnt++;
    if (busy0 !== 1'b1 || data0 !== 8'd1) begin
      err_cnt++;
      $display("FAIL b2b_restart cyc25 busy/data got %b/%0d want 1/1", busy0, data0);
    end
    repeat (4) @(negedge clk);
    start0 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (done0 === 1'b1) seen = 1'b1;
    end
    vec_cnt++;
    if (!seen) begin
      err_cnt++;
      $display("FAIL b2b_second_done got none within 60 cycles want 1");
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (busy0 !== 1'b0 || result0 !== 8'd27) begin
      err_cnt++;
      $display("FAIL b2b_settle busy/result got %b/%0d want 0/27", busy0, result0);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    op_a = 8'd7; op_b = 8'd8; op_c = 8'd9; op_x = 8'd10;
    launch(0);
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (go0 !== 1'b1 || data0 !== 8'd8) begin
      err_cnt++;
      $display("FAIL rstmid_press cyc6 go/data got %b/%0d want 1/8", go0, data0);
    end
    resetn = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({go0, busy0, done0, data0, result0} !== 19'd0) begin
      err_cnt++;
      $display("FAIL rstmid_abort go/busy/done/data/result got %b/%b/%b/%0d/%0d want all 0",
               go0, busy0, done0, data0, result0);
    end
    resetn = 1'b1;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || go0 !== 1'b0 || busy0 !== 1'b0) bad++;
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL rstmid_quiet got %0d active cycles in 40 want 0", bad);
    end
  endtask

  task automatic test_op_change();
    logic eg, eb, edn;
    logic [7:0] ed;
    op_a = 8'd2; op_b = 8'd3; op_c = 8'd1; op_x = 8'd2;
    launch(0);
    for (int k = 1; k <= 24; k++) begin
      exp_at(k, 2, 1, 6, 32'h02030102, eg, ed, eb, edn);
      vec_cnt++;
      if ({go0, data0, busy0, done0} !== {eg, ed, eb, edn}) begin
        err_cnt++;
        $display("FAIL opchg cyc%0d go/data/busy/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 k, go0, data0, busy0, done0, eg, ed, eb, edn);
      end
      if (k == 6) begin
        op_a = 8'd9; op_b = 8'd9; op_c = 8'd9; op_x = 8'd9;
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (result0 !== 8'd15) begin
      err_cnt++;
      $display("FAIL opchg_result got %0d want 15", result0);
    end
  endtask

  task automatic test_params();
    logic eg, eb, edn;
    logic [7:0] ed;
    int done_cyc;
    op_a = 8'h11; op_b = 8'h22; op_c = 8'h33; op_x = 8'h44;
    res_in1 = 8'hA5;
    launch(1);
    done_cyc = -1;
    for (int k = 1; k <= 29; k++) begin
      exp_at(k, 1, 3, 5, 32'h11223344, eg, ed, eb, edn);
      vec_cnt++;
      if ({go1, data1, busy1, done1} !== {eg, ed, eb, edn}) begin
        err_cnt++;
        $display("FAIL params cyc%0d go/data/busy/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 k, go1, data1, busy1, done1, eg, ed, eb, edn);
      end
      if (done1 === 1'b1) done_cyc = k;
      // start while busy must be ignored
      if (k == 10) start1 = 1'b1;
      if (k == 11) start1 = 1'b0;
      @(negedge clk);
    end
    vec_cnt++;
    if (done_cyc != 26) begin
      err_cnt++;
      $display("FAIL params_done_cycle got %0d want 26", done_cyc);
    end
    vec_cnt++;
    if (result1 !== 8'hA5) begin
      err_cnt++;
      $display("FAIL params_result got %h want a5", result1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_eval();
    test_back_to_back();
    test_reset_mid();
    test_op_change();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/poly_loader_driver.md
POLY_LOADER_DRIVER -- requirements
Module: poly_loader_driver

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 2, number of cycles go is held high per operand (legal range 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, number of setup cycles data_out is stable with go low before each press (legal range 1..255).
REQ-003 SHALL have parameter RESULT_WAIT, default 6, number of cycles waited after the last release before sampling result_in (legal range 5..255).
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request to send one operand set; sampled only in IDLE.
REQ-007 op_a, op_b, op_c, op_x  input  8 each  polynomial operands, captured on accepted start.
REQ-008 result_in  input  8  result register of the downstream polynomial evaluator.
REQ-009 go  output  1  active-high load strobe to evaluator (press/release protocol).
REQ-010 data_out  output  8  operand bus to evaluator.
REQ-011 busy  output  1  high while a transaction is in progress, including the DONE cycle.
REQ-012 done  output  1  single-cycle pulse when result is valid.
REQ-013 result  output  8  captured evaluator result; holds until next capture.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, PRESS, RELEASE, WAIT_RES, DONE.
REQ-015 IDLE: start=1 SHALL capture op_a..op_x into internal registers, clear operand index to 0, load down-counter with GAP_CYCLES, go to SETUP; start=0 stays IDLE.
REQ-016 Operand index SHALL select data_out: 0=a, 1=b, 2=c, 3=x; data_out SHALL be 0 in IDLE, and hold the indexed operand in SETUP, PRESS and RELEASE.
REQ-017 SETUP: go=0 for exactly GAP_CYCLES cycles, then PRESS with counter loaded to PULSE_CYCLES.
REQ-018 PRESS: go=1 for exactly PULSE_CYCLES cycles, then RELEASE.
REQ-019 RELEASE: go=0, data_out unchanged, exactly 1 cycle; if index<3, increment index and go to SETUP; if index=3, load RESULT_WAIT and go to WAIT_RES.
REQ-020 go SHALL never be high for consecutive operands without at least 1 RELEASE and GAP_CYCLES SETUP cycles between pulses.
REQ-021 Exactly four go pulses SHALL be issued per transaction, in order a, b, c, x.
REQ-022 WAIT_RES: go=0, data_out=0, for exactly RESULT_WAIT cycles, then DONE.
REQ-023 DONE: result <= result_in at the edge entering DONE; done=1 for that one cycle; next state IDLE.
REQ-024 start asserted outside IDLE SHALL be ignored (not queued); operand inputs changing mid-transaction SHALL not affect data_out.
REQ-025 Counters SHALL be 8-bit down-counters; parameter values outside legal range are a configuration error, not handled.
REQ-026 With defaults, start sampled at edge 0 SHALL give first go rise at cycle 2, done high in cycle 23, busy high cycles 1..23.

Reset
REQ-027 resetn=0 at any posedge SHALL force IDLE, go=0, data_out=0, busy=0, done=0, result=0, index=0, counters=0, operand registers=0.
REQ-028 Reset mid-transaction SHALL abort immediately without completing the pulse; no done pulse SHALL follow.

Structure
REQ-029 State encodings and operand-index constants SHALL live in the shared poly package alongside the evaluator's state constants.
REQ-030 Single module, no sub-module; one state register, one shared down-counter, one 2-bit index register.

Verification
REQ-031 Defaults, a=1,b=2,c=3,x=4, start 1 cycle -> go pulses of 2 cycles at cycles 2,6,10,14 with data_out 1,2,3,4; done at 23.
REQ-032 Driver connected to evaluator, a=5,b=0,c=0,x=0 -> result equals evaluator reference model output, done single cycle.
REQ-033 start held high for 30 cycles -> exactly one transaction before return to IDLE, second starts only on start re-sampled in IDLE.
REQ-034 resetn low during second PRESS -> next cycle go=0, busy=0, result=0, no done for 40 cycles.
REQ-035 PULSE_CYCLES=1, GAP_CYCLES=3, RESULT_WAIT=5 -> go pulses 1 cycle wide, 3 setup cycles each, done at cycle 26.
REQ-036 op_a changed during PRESS of operand b -> data_out and evaluator load unaffected.
